sram_like_bridge: RTL

//  Converts the CPU core's zero-wait SRAM-style ports (en/wen/addr/wdata/rdata) into
//  NUM_CH independent sram-like handshake channels (req/addr_ok/data_ok); ch0 = inst, ch1 = data.

---
 rtl/sram_like_bridge_pkg.sv | 34 +++
 rtl/sram_like_chan.sv | 187 ++++++++++++++++++
 rtl/sram_like_bridge.sv | 84 ++++++++
 3 files changed

// File: rtl/sram_like_bridge_pkg.sv
// ---------------------------------------------------------------------------
// sram_like_bridge_pkg
//   Shared definitions for the SRAM-port to sram-like handshake bridge:
//   per-channel state encoding, bus transfer size codes and the kseg0/kseg1
//   virtual-to-physical address fold.
// ---------------------------------------------------------------------------
package sram_like_bridge_pkg;

   // Per-channel FSM state. The numeric values are visible on the debug port.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,  // no access outstanding
      ST_REQ  = 2'd1,  // request presented, waiting for addr_ok
      ST_WAIT = 2'd2,  // request accepted, waiting for data_ok
      ST_DONE = 2'd3   // response received, read data held for the pipeline
   } chan_state_t;

   // bus_size encoding
   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam int KSEG_ADDR_W = 32;

   // kseg0 (0x8000_0000..0x9FFF_FFFF) and kseg1 (0xA000_0000..0xBFFF_FFFF)
   // both map onto the low 512 MB of physical space; the remaining segments
   // pass through untranslated.
   function automatic logic [KSEG_ADDR_W-1:0] kseg_fold(input logic [KSEG_ADDR_W-1:0] vaddr);
      if (vaddr[KSEG_ADDR_W-1 -: 2] == 2'b10) begin
         return {3'b000, vaddr[KSEG_ADDR_W-4:0]};
      end
      return vaddr;
   endfunction

endpackage

// File: rtl/sram_like_chan.sv
// ---------------------------------------------------------------------------
// sram_like_chan
//   One bridge channel: converts a zero-wait SRAM-style access into a single
//   sram-like transaction (req/addr_ok/data_ok) and holds the read data until
//   the pipeline advances.
//
//   Handshake: bus_req is asserted from the cycle the access is issued until
//   the cycle bus_addr_ok is seen high at a rising edge, and is never
//   retracted in between; bus_addr/wr/size/wdata stay stable while bus_req is
//   high. Exactly one bus_data_ok is expected per accepted request, no earlier
//   than the cycle after addr_ok.
//
// Ports
//   clk, resetn           clock, asynchronous active-low reset
//   cpu_en/wen/addr/wdata SRAM-style access from the core
//   cpu_rdata             read data held from the last completed read
//   cpu_flush             pipeline flush: cancels any access in flight
//   cpu_stall             global stall (OR of all channels) fed back in
//   stall_ch              this channel's stall contribution
//   bus_*                 sram-like master port
//   state                 current FSM state (debug)
// ---------------------------------------------------------------------------
module sram_like_chan
   import sram_like_bridge_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MAP_EN = 1
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                cpu_en,
   input  logic [DATA_W/8-1:0] cpu_wen,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [DATA_W-1:0]   cpu_wdata,
   output logic [DATA_W-1:0]   cpu_rdata,
   input  logic                cpu_flush,
   input  logic                cpu_stall,
   output logic                stall_ch,
   output logic                bus_req,
   output logic                bus_wr,
   output logic [1:0]          bus_size,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic                bus_addr_ok,
   input  logic                bus_data_ok,
   input  logic [DATA_W-1:0]   bus_rdata,
   output chan_state_t         state
);

   localparam int BE_W = DATA_W / 8;
   localparam logic [BE_W-1:0] BE_ONE  = {{(BE_W-1){1'b0}}, 1'b1};
   localparam logic [BE_W-1:0] HALF_LO = {{(BE_W/2){1'b0}}, {(BE_W/2){1'b1}}};
   localparam logic [BE_W-1:0] HALF_HI = {{(BE_W/2){1'b1}}, {(BE_W/2){1'b0}}};

   chan_state_t       state_q, state_d;
   logic              cancel_q, cancel_d;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              issue;
   logic [1:0]        size_dec;
   logic              size_legal;
   logic [ADDR_W-1:0] addr_phys;

   // Issue is gated with resetn so that the bus side is quiet for the whole
   // reset pulse even if the core keeps cpu_en high.
   assign issue = (state_q == ST_IDLE) & cpu_en & ~cpu_flush & resetn;

   // Byte-enable to transfer size. Reads are always issued as full words.
   always_comb begin
      size_dec   = SIZE_WORD;
      size_legal = 1'b1;
      if ((cpu_wen == '0) || (cpu_wen == '1)) begin
         size_dec = SIZE_WORD;
      end else if ((cpu_wen == HALF_LO) || (cpu_wen == HALF_HI)) begin
         size_dec = SIZE_HALF;
      end else if ((cpu_wen & (cpu_wen - BE_ONE)) == '0) begin
         size_dec = SIZE_BYTE;
      end else begin
         size_legal = 1'b0;
      end
   end

   assign addr_phys = (MAP_EN != 0) ? kseg_fold(cpu_addr) : cpu_addr;

   always_comb begin
      state_d  = state_q;
      cancel_d = cancel_q;
      wr_d     = wr_q;
      size_d   = size_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      case (state_q)
         ST_IDLE: begin
            cancel_d = 1'b0;
            if (issue) begin
               wr_d    = |cpu_wen;
               size_d  = size_dec;
               addr_d  = addr_phys;
               wdata_d = cpu_wdata;
               state_d = bus_addr_ok ? ST_WAIT : ST_REQ;
            end
         end
         ST_REQ: begin
            // A flushed request cannot be withdrawn; it is drained instead.
            if (cpu_flush) cancel_d = 1'b1;
            if (bus_addr_ok) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cpu_flush) cancel_d = 1'b1;
            if (bus_data_ok) begin
               if (cancel_q || cpu_flush) begin
                  // Response belongs to a flushed instruction: drop it.
                  state_d  = ST_IDLE;
                  cancel_d = 1'b0;
               end else begin
                  state_d = ST_DONE;
                  if (!wr_q) rdata_d = bus_rdata;
               end
            end
         end
         ST_DONE: begin
            // Hold until every channel is ready; the pipeline samples
            // cpu_rdata on the edge where the stall drops.
            if (!cpu_stall || cpu_flush) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         cancel_q <= 1'b0;
         wr_q     <= 1'b0;
         size_q   <= SIZE_BYTE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cancel_q <= cancel_d;
         wr_q     <= wr_d;
         size_q   <= size_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
      end
   end

   // In the issue cycle the bus sees the live core request; afterwards the
   // latched copy. Everything reads as zero when no request is presented.
   always_comb begin
      bus_req   = 1'b0;
      bus_wr    = 1'b0;
      bus_size  = SIZE_BYTE;
      bus_addr  = '0;
      bus_wdata = '0;
      if (issue) begin
         bus_req   = 1'b1;
         bus_wr    = |cpu_wen;
         bus_size  = size_dec;
         bus_addr  = addr_phys;
         bus_wdata = cpu_wdata;
      end else if (state_q == ST_REQ) begin
         bus_req   = 1'b1;
         bus_wr    = wr_q;
         bus_size  = size_q;
         bus_addr  = addr_q;
         bus_wdata = wdata_q;
      end
   end

   assign stall_ch  = issue | (state_q == ST_REQ) | (state_q == ST_WAIT);
   assign cpu_rdata = rdata_q;
   assign state     = state_q;

   a_wen_legal: assert property (@(posedge clk) disable iff (!resetn) issue |-> size_legal);
   a_data_ok_in_wait: assert property (@(posedge clk) disable iff (!resetn)
      bus_data_ok |-> (state_q == ST_WAIT));

endmodule

// File: rtl/sram_like_bridge.sv
// ---------------------------------------------------------------------------
// sram_like_bridge
//   Bridges the core's zero-wait SRAM ports onto NUM_CH independent
//   sram-like channels (ch0 = instruction, ch1 = data) and produces one
//   global pipeline stall.
//
// Ports (all per-channel buses are flattened, channel i in slice i)
//   clk, resetn                       clock, asynchronous active-low reset
//   cpu_en/wen/addr/wdata, cpu_rdata  core-side SRAM ports
//   cpu_flush                         pipeline flush
//   cpu_stall                         global stall
//   bus_req/wr/size/addr/wdata        sram-like request side
//   bus_addr_ok/data_ok/rdata         sram-like response side
//   dbg_state                         2-bit FSM state per channel
// ---------------------------------------------------------------------------
module sram_like_bridge
   import sram_like_bridge_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MAP_EN = 1
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [NUM_CH-1:0]          cpu_en,
   input  logic [NUM_CH*DATA_W/8-1:0] cpu_wen,
   input  logic [NUM_CH*ADDR_W-1:0]   cpu_addr,
   input  logic [NUM_CH*DATA_W-1:0]   cpu_wdata,
   output logic [NUM_CH*DATA_W-1:0]   cpu_rdata,
   input  logic                       cpu_flush,
   output logic                       cpu_stall,
   output logic [NUM_CH-1:0]          bus_req,
   output logic [NUM_CH-1:0]          bus_wr,
   output logic [NUM_CH*2-1:0]        bus_size,
   output logic [NUM_CH*ADDR_W-1:0]   bus_addr,
   output logic [NUM_CH*DATA_W-1:0]   bus_wdata,
   input  logic [NUM_CH-1:0]          bus_addr_ok,
   input  logic [NUM_CH-1:0]          bus_data_ok,
   input  logic [NUM_CH*DATA_W-1:0]   bus_rdata,
   output logic [NUM_CH*2-1:0]        dbg_state
);

   localparam int BE_W = DATA_W / 8;

   logic [NUM_CH-1:0] stall_ch;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      chan_state_t st;

      sram_like_chan #(
         .ADDR_W (ADDR_W),
         .DATA_W (DATA_W),
         .MAP_EN (MAP_EN)
      ) u_chan (
         .clk         (clk),
         .resetn      (resetn),
         .cpu_en      (cpu_en[g]),
         .cpu_wen     (cpu_wen[g*BE_W +: BE_W]),
         .cpu_addr    (cpu_addr[g*ADDR_W +: ADDR_W]),
         .cpu_wdata   (cpu_wdata[g*DATA_W +: DATA_W]),
         .cpu_rdata   (cpu_rdata[g*DATA_W +: DATA_W]),
         .cpu_flush   (cpu_flush),
         .cpu_stall   (cpu_stall),
         .stall_ch    (stall_ch[g]),
         .bus_req     (bus_req[g]),
         .bus_wr      (bus_wr[g]),
         .bus_size    (bus_size[g*2 +: 2]),
         .bus_addr    (bus_addr[g*ADDR_W +: ADDR_W]),
         .bus_wdata   (bus_wdata[g*DATA_W +: DATA_W]),
         .bus_addr_ok (bus_addr_ok[g]),
         .bus_data_ok (bus_data_ok[g]),
         .bus_rdata   (bus_rdata[g*DATA_W +: DATA_W]),
         .state       (st)
      );

      assign dbg_state[g*2 +: 2] = st;
   end

   // A channel sitting in DONE contributes no stall but still waits here for
   // the slowest channel before returning to IDLE.
   assign cpu_stall = |stall_ch;

endmodule
